id_stage_p: RTL
===============

# id_stage_p

Parametrised instruction-decode stage for the 16-bit-instruction pipelined processor. It decodes the IF/ID instruction, reads a 16-entry register file with write-to-read bypass, detects load-use and jump-register hazards, and resolves JAL/JR in decode. It registers all decoded controls and operands into an internal ID/EX pipeline register. It sits between the IF stage, which it can stall, and the EX stage, which it feeds. Flush, stall and halt are handled internally.

## Interface
- DATA_W, 16: register and operand width (≥16).
- PC_W, 16: PC width.
- LINK_REG, 15: JAL link destination.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- instr  in  16  instruction in ID.
- pc  in  PC_W  PC of instr.
- ex_stall  in  1  EX cannot accept; hold ID/EX.
- flush  in  1  taken branch in EX; kill ID content.
- mem_we_rf / mem_dst_addr  in  1 / 4  register write pending in MEM.
- wb_we / wb_addr / wb_data  in  1 / 4 / DATA_W  register-file write port.
- id_stall  out  1  IF must hold PC and IF/ID.
- j_ctrl / j_pc  out  1 / PC_W  redirect IF this cycle.
- halted  out  1  sticky; HLT has been decoded.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_p0, ex_p1  out  DATA_W  operands.
- ex_imm8 / ex_shamt / ex_func  out  8 / 4 / 3  immediate, shift amount, ALU function.
- ex_src1sel, ex_we_rf, ex_re_mem, ex_we_mem, ex_wb_sel, ex_hlt  out  1 each.
- ex_dst_addr  out  4  destination register.
- ex_pc  out  PC_W  PC of the EX instruction.

## Operation
- **Fields.** op = instr[15:12], rd = [11:8], rs = [7:4], rt = [3:0].
- **Opcode groups.**
  - ALU (op 0000–0111): func = op[2:0]; p0 = rs; p1 = rt; shamt = rt; we_rf = 1; dst = rd.
  - LW (1000) / SW (1001): p0 = rs; src1sel = 1; imm8 = instr[7:0].
    - LW: re_mem = 1, wb_sel = 1, we_rf = 1, dst = rd.
    - SW: p1 = rd, we_mem = 1.
  - LHB (1010) / LLB (1011): p0 = rd; imm8 = instr[7:0]; src1sel = 1; we_rf = 1; dst = rd.
  - B (1100): no RF write; passed to EX.
  - JAL (1101):
    - j_pc = pc + 1 + sign-extended instr[11:0], modulo 2^PC_W.
    - ID/EX receives we_rf = 1, dst = LINK_REG, p0 = zero-extended pc + 1, p1 = 0, func = 000 (ADD), src1sel = 0.
    - The link value is written through WB, so there is no second write port.
  - JR (1110): j_pc = RF[rs] (low PC_W bits); no RF write.
  - HLT (1111): ex_hlt = 1; halted sets at the same edge.
- **Register file.**
  - 16 × DATA_W flops; written at posedge when wb_we and wb_addr ≠ 0.
  - R0 always reads 0.
  - Bypass: a read of address a returns wb_data when wb_we, wb_addr == a and a ≠ 0.
- **Load-use hazard.**
  - Condition: ex_valid & ex_re_mem & ex_dst_addr ≠ 0 & ex_dst_addr matches a register used by the ID instruction (p0 or p1 source).
  - Response: id_stall = 1 for one cycle; a bubble is loaded into ID/EX.
- **JR hazard.**
  - Condition: rs ≠ 0 matches (ex_valid & ex_we_rf & ex_dst_addr) or (mem_we_rf & mem_dst_addr).
  - Response: stall and insert bubbles until clear. WB-stage writes are covered by the bypass.
- **Jumps.** j_ctrl = valid_id & (JAL | JR) & ~id_stall, where valid_id = if_valid & ~flush & ~halted.
- **Halt.**
  - After halted, valid_id = 0; subsequent instructions become bubbles.
  - halted clears only on rst.

## Timing
- **Reset.** On rst at posedge: all RF entries, all ex_* outputs, ex_valid and halted become 0. Combinational outputs (j_ctrl, id_stall) are 0 while halted = 0 and if_valid = 0.
- **ID/EX load priority at posedge:**
  - rst → zero;
  - else flush → bubble (ex_valid = 0, all write/mem enables 0);
  - else ex_stall → hold;
  - else hazard → bubble;
  - else load the decoded valid_id instruction.
- **id_stall** = valid_id & (hazard | ex_stall).
- **Latency.** ID → ID/EX is 1 cycle. j_pc and j_ctrl are combinational in the same cycle. RF write is visible through the bypass in the same cycle and from the register the next cycle.
- **Flush.**
  - flush asserted with a hazard: flush wins; id_stall = 0 (the killed instruction is dropped).
  - flush with ex_stall: flush wins.
- **Reset mid-stall.** rst while a stall is pending clears it; there is no residual stall next cycle.
- **Arithmetic.** pc + 1 wraps at 2^PC_W.

## Test plan
- **Reset.** Assert rst 2 cycles, then check ex_valid = 0, halted = 0, RF[1..15] reads 0.
- **Bypass and R0.** wb_we = 1, wb_addr = 3, wb_data = 0x1234, with ADD rd=1 rs=3 rt=0 in ID → ex_p0 = 0x1234 and ex_p1 = 0 next edge. A write to R0 never reads back nonzero.
- **Load-use.** LW R2 followed by ADD R4,R2,R5 → id_stall = 1 for exactly 1 cycle; ex_valid = 0 once; then the ADD appears with ex_valid = 1.
- **JAL.**
  - JAL at pc = 0x0010, offset 0x005 → j_ctrl = 1, j_pc = 0x0016 in the same cycle.
  - Next cycle: ex_dst_addr = 15, ex_p0 = 0x0011, ex_we_rf = 1.
  - With offset 0xFFF at pc = 0 → j_pc = 0x0000.
- **JR hazard.** ADD R7 in ID/EX, then JR R7 with mem_we_rf = 1 and mem_dst_addr = 7 on the following cycle → 2 stall cycles; j_pc equals wb_data when the write reaches WB.
- **Flush and halt.**
  - flush during a load-use stall → bubble, id_stall = 0.
  - HLT → halted = 1; later instructions give ex_valid = 0 until rst.

Source files
------------

// File: rtl/id_stage_p.sv
// id_stage_p: instruction-decode stage of the 16-bit-instruction pipeline.
//
// Decodes the IF/ID instruction, reads a 16-entry register file (with a
// same-cycle write-to-read bypass from WB), detects load-use and
// jump-register hazards, resolves JAL/JR in decode and registers all
// decoded controls and operands into the ID/EX pipeline register.
//
// Ports:
//   clk, rst                       clock (rising edge), sync active-high reset
//   if_valid, instr, pc            IF/ID contents
//   ex_stall                       EX cannot accept; hold ID/EX
//   flush                          taken branch in EX; kill ID content
//   mem_we_rf, mem_dst_addr        register write pending in MEM
//   wb_we, wb_addr, wb_data        register-file write port
//   id_stall                       IF must hold PC and IF/ID
//   j_ctrl, j_pc                   redirect IF this cycle (JAL/JR)
//   halted                         sticky, set when HLT enters ID/EX
//   ex_*                           ID/EX register contents
//
// Handshake: an instruction leaves ID at a rising edge exactly when
// valid_id is high and id_stall is low; while id_stall is high IF must
// present the same instruction again on the next cycle.

module id_stage_p #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int LINK_REG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       instr,
    input  logic [PC_W-1:0]   pc,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              mem_we_rf,
    input  logic [3:0]        mem_dst_addr,
    input  logic              wb_we,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              j_ctrl,
    output logic [PC_W-1:0]   j_pc,
    output logic              halted,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_p0,
    output logic [DATA_W-1:0] ex_p1,
    output logic [7:0]        ex_imm8,
    output logic [3:0]        ex_shamt,
    output logic [2:0]        ex_func,
    output logic              ex_src1sel,
    output logic              ex_we_rf,
    output logic              ex_re_mem,
    output logic              ex_we_mem,
    output logic              ex_wb_sel,
    output logic              ex_hlt,
    output logic [3:0]        ex_dst_addr,
    output logic [PC_W-1:0]   ex_pc
);

    localparam logic [3:0] LINK_ADDR = LINK_REG[3:0];

    logic [DATA_W-1:0] r_rf [16];
    logic              r_halted;

    logic [3:0]        w_op, w_rd, w_rs, w_rt;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_rd_val;
    logic [PC_W-1:0]   w_pc_inc, w_jal_tgt, w_jr_tgt;
    logic              w_valid_id, w_is_jal, w_is_jr, w_is_hlt;
    logic              w_use_rs, w_use_rt, w_use_rd;
    logic              w_load_use, w_jr_haz, w_hazard;

    // decoded ID/EX payload
    logic [DATA_W-1:0] w_p0, w_p1;
    logic [7:0]        w_imm8;
    logic [3:0]        w_shamt, w_dst;
    logic [2:0]        w_func;
    logic              w_src1sel, w_we_rf, w_re_mem, w_we_mem, w_wb_sel, w_hlt;

    assign w_op = instr[15:12];
    assign w_rd = instr[11:8];
    assign w_rs = instr[7:4];
    assign w_rt = instr[3:0];

    // R0 reads zero; a WB write to the same address is forwarded this cycle.
    assign w_rs_val = (w_rs == 4'd0) ? '0 : (wb_we && wb_addr == w_rs) ? wb_data : r_rf[w_rs];
    assign w_rt_val = (w_rt == 4'd0) ? '0 : (wb_we && wb_addr == w_rt) ? wb_data : r_rf[w_rt];
    assign w_rd_val = (w_rd == 4'd0) ? '0 : (wb_we && wb_addr == w_rd) ? wb_data : r_rf[w_rd];

    assign w_valid_id = if_valid & ~flush & ~r_halted;
    assign w_is_jal   = (w_op == 4'b1101);
    assign w_is_jr    = (w_op == 4'b1110);
    assign w_is_hlt   = (w_op == 4'b1111);

    assign w_pc_inc  = pc + 1'b1;
    assign w_jal_tgt = w_pc_inc + PC_W'($signed(instr[11:0]));
    assign w_jr_tgt  = w_rs_val[PC_W-1:0];

    always_comb begin
        w_p0      = '0;
        w_p1      = '0;
        w_imm8    = '0;
        w_shamt   = '0;
        w_func    = '0;
        w_dst     = '0;
        w_src1sel = 1'b0;
        w_we_rf   = 1'b0;
        w_re_mem  = 1'b0;
        w_we_mem  = 1'b0;
        w_wb_sel  = 1'b0;
        w_hlt     = 1'b0;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_use_rd  = 1'b0;
        if (w_op[3] == 1'b0) begin
            // ALU group
            w_func   = w_op[2:0];
            w_p0     = w_rs_val;
            w_p1     = w_rt_val;
            w_shamt  = w_rt;
            w_we_rf  = 1'b1;
            w_dst    = w_rd;
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
        end else begin
            case (w_op[2:0])
                3'b000, 3'b001: begin
                    w_p0      = w_rs_val;
                    w_src1sel = 1'b1;
                    w_imm8    = instr[7:0];
                    w_use_rs  = 1'b1;
                    if (w_op[0] == 1'b0) begin
                        w_re_mem = 1'b1;
                        w_wb_sel = 1'b1;
                        w_we_rf  = 1'b1;
                        w_dst    = w_rd;
                    end else begin
                        w_p1     = w_rd_val;
                        w_we_mem = 1'b1;
                        w_use_rd = 1'b1;
                    end
                end
                3'b010, 3'b011: begin
                    // func low bit tells EX whether it is LHB or LLB
                    w_func    = w_op[2:0];
                    w_p0      = w_rd_val;
                    w_imm8    = instr[7:0];
                    w_src1sel = 1'b1;
                    w_we_rf   = 1'b1;
                    w_dst     = w_rd;
                    w_use_rd  = 1'b1;
                end
                3'b100: begin
                    // branch: offset travels to EX, which resolves it
                    w_imm8 = instr[7:0];
                end
                3'b101: begin
                    // JAL: link value goes down the pipe as pc+1 + 0 via ADD
                    w_p0    = DATA_W'(w_pc_inc);
                    w_we_rf = 1'b1;
                    w_dst   = LINK_ADDR;
                end
                3'b110: begin
                    // JR: target taken from RF in decode, nothing written
                end
                default: begin
                    w_hlt = 1'b1;
                end
            endcase
        end
    end

    assign w_load_use = ex_valid & ex_re_mem & (ex_dst_addr != 4'd0) &
                        ((w_use_rs & (w_rs == ex_dst_addr)) |
                         (w_use_rt & (w_rt == ex_dst_addr)) |
                         (w_use_rd & (w_rd == ex_dst_addr)));

    // JR reads its target in ID, so any in-flight write to rs must drain
    // to WB, where the bypass covers it.
    assign w_jr_haz = w_is_jr & (w_rs != 4'd0) &
                      ((ex_valid & ex_we_rf & (ex_dst_addr == w_rs)) |
                       (mem_we_rf & (mem_dst_addr == w_rs)));

    assign w_hazard = w_valid_id & (w_load_use | w_jr_haz);
    assign id_stall = w_valid_id & (w_load_use | w_jr_haz | ex_stall);
    assign j_ctrl   = w_valid_id & (w_is_jal | w_is_jr) & ~id_stall;
    assign j_pc     = w_is_jr ? w_jr_tgt : w_jal_tgt;
    assign halted   = r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (wb_we && wb_addr != 4'd0) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (!ex_stall && (w_hazard || !w_valid_id))) begin
            // reset, flush and hazard/idle bubbles all clear ID/EX
            ex_valid    <= 1'b0;
            ex_p0       <= '0;
            ex_p1       <= '0;
            ex_imm8     <= '0;
            ex_shamt    <= '0;
            ex_func     <= '0;
            ex_src1sel  <= 1'b0;
            ex_we_rf    <= 1'b0;
            ex_re_mem   <= 1'b0;
            ex_we_mem   <= 1'b0;
            ex_wb_sel   <= 1'b0;
            ex_hlt      <= 1'b0;
            ex_dst_addr <= '0;
            ex_pc       <= '0;
        end else if (!ex_stall) begin
            ex_valid    <= 1'b1;
            ex_p0       <= w_p0;
            ex_p1       <= w_p1;
            ex_imm8     <= w_imm8;
            ex_shamt    <= w_shamt;
            ex_func     <= w_func;
            ex_src1sel  <= w_src1sel;
            ex_we_rf    <= w_we_rf;
            ex_re_mem   <= w_re_mem;
            ex_we_mem   <= w_we_mem;
            ex_wb_sel   <= w_wb_sel;
            ex_hlt      <= w_hlt;
            ex_dst_addr <= w_dst;
            ex_pc       <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_valid_id && !ex_stall && !w_hazard && w_is_hlt) begin
            r_halted <= 1'b1;
        end
    end

endmodule
